rm_lane_allocator: RTL

// - Allocates free runtime-monitor lanes to monitored instructions at issue and drives the
//   rm_event_router monitor_i port (runtime_monitor_ctrl).
// - Tracks which lanes are busy and frees each lane when the router pulses lane_reset_o.
// - Back-pressures issue when too few lanes are free, and sequences a flush that drains

---
 rtl/rm_lane_allocator_pkg.sv | 31 +++
 rtl/rm_lane_allocator_if.sv | 23 ++
 rtl/rm_lane_allocator_picker.sv | 35 +++
 rtl/rm_lane_allocator.sv | 115 +++++++++++
 4 files changed

// File: rtl/rm_lane_allocator_pkg.sv
// Shared types for the runtime-monitor lane allocator: lane geometry, the
// monitored instruction type, the router control word and the allocator FSM states.
package rm_lane_allocator_pkg;

  localparam int RM_NUM_LANES = 5;
  localparam int RM_LANE_W    = $clog2(RM_NUM_LANES);
  localparam int RM_CNT_W     = $clog2(RM_NUM_LANES + 1);

  typedef enum logic [1:0] {
    RM_ITYPE_LOAD   = 2'd0,
    RM_ITYPE_STORE  = 2'd1,
    RM_ITYPE_BRANCH = 2'd2,
    RM_ITYPE_CALL   = 2'd3
  } monitored_itype;

  typedef struct packed {
    logic                 monitor_ins;
    logic [RM_LANE_W-1:0] idx;
    logic [RM_LANE_W-1:0] p_idx;
    monitored_itype       itype;
    logic                 two_lane;
    logic [RM_LANE_W-1:0] lane0;
    logic [RM_LANE_W-1:0] lane1;
  } runtime_monitor_ctrl;

  typedef enum logic {
    RM_ALLOC_RUN,
    RM_ALLOC_FLUSH
  } rm_alloc_state_e;

endpackage

// File: rtl/rm_lane_allocator_if.sv
// Issue-side request handshake plus the registered control word sent to the event router.
interface rm_lane_allocator_if;
  import rm_lane_allocator_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [RM_LANE_W-1:0] req_idx;
  logic [RM_LANE_W-1:0] req_p_idx;
  monitored_itype       req_itype;
  logic                 req_two_lane;
  runtime_monitor_ctrl  monitor;

  modport master (
    output req_valid, req_idx, req_p_idx, req_itype, req_two_lane,
    input  req_ready, monitor
  );

  modport slave (
    input  req_valid, req_idx, req_p_idx, req_itype, req_two_lane,
    output req_ready, monitor
  );

endinterface

// File: rtl/rm_lane_allocator_picker.sv
// Combinational find-first-two over the free map, plus a popcount of free lanes.
module rm_free_lane_picker #(
  parameter int NUM_LANES = 5,
  parameter int LANE_W    = $clog2(NUM_LANES),
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0] free_map,
  output logic [LANE_W-1:0]    lane0,
  output logic [LANE_W-1:0]    lane1,
  output logic                 lane0_vld,
  output logic                 lane1_vld,
  output logic [CNT_W-1:0]     free_cnt
);

  always_comb begin
    lane0     = '0;
    lane1     = '0;
    lane0_vld = 1'b0;
    lane1_vld = 1'b0;
    free_cnt  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (free_map[i]) begin
        if (!lane0_vld) begin
          lane0     = LANE_W'(i);
          lane0_vld = 1'b1;
        end else if (!lane1_vld) begin
          lane1     = LANE_W'(i);
          lane1_vld = 1'b1;
        end
        free_cnt = free_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rm_lane_allocator.sv
// Hands free monitor lanes to monitored instructions at issue, frees them on router
// release pulses, back-pressures issue and drains every lane on a flush.
module rm_lane_allocator
  import rm_lane_allocator_pkg::*;
#(
  parameter int NUM_LANES = RM_NUM_LANES,
  parameter int STALL_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rm_lane_allocator_if.slave   bus,
  input  logic [NUM_LANES-1:0] lane_release_i,
  input  logic                 flush_i,
  output logic [$clog2(NUM_LANES+1)-1:0] free_cnt_o,
  output logic [STALL_W-1:0]   stall_cnt_o,
  output logic                 err_o
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int CNT_W  = $clog2(NUM_LANES + 1);

  rm_alloc_state_e      state_reg, state_next;
  logic [NUM_LANES-1:0] free_map_reg, free_map_next, alloc_mask;
  runtime_monitor_ctrl  monitor_reg, monitor_next;
  logic [STALL_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic                 err_reg, err_next;

  logic [LANE_W-1:0]    pick_lane0, pick_lane1;
  logic                 pick_lane0_vld, pick_lane1_vld;
  logic [CNT_W-1:0]     free_cnt;
  logic                 req_ready, handshake;

  rm_free_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W),
    .CNT_W     (CNT_W)
  ) u_picker (
    .free_map  (free_map_reg),
    .lane0     (pick_lane0),
    .lane1     (pick_lane1),
    .lane0_vld (pick_lane0_vld),
    .lane1_vld (pick_lane1_vld),
    .free_cnt  (free_cnt)
  );

  // Held low in reset so nothing upstream sees a handshake before the lanes are known free.
  assign req_ready = rst_ni & (state_reg == RM_ALLOC_RUN) & ~flush_i &
                     ((free_cnt >= CNT_W'(2)) |
                      ((free_cnt >= CNT_W'(1)) & ~bus.req_two_lane));
  assign handshake = bus.req_valid & req_ready;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_alloc
    assign alloc_mask[gi] = handshake &
        ((pick_lane0_vld & (pick_lane0 == LANE_W'(gi))) |
         (bus.req_two_lane & pick_lane1_vld & (pick_lane1 == LANE_W'(gi))));
  end

  assign free_map_next = (free_map_reg & ~alloc_mask) | lane_release_i;
  assign err_next      = err_reg | (|(lane_release_i & free_map_reg));

  // Leaving FLUSH keys off the post-release map so issue resumes right after the last release.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RM_ALLOC_RUN:   if (flush_i) state_next = RM_ALLOC_FLUSH;
      RM_ALLOC_FLUSH: if (&free_map_next) state_next = RM_ALLOC_RUN;
      default:        state_next = RM_ALLOC_RUN;
    endcase
  end

  always_comb begin
    monitor_next = '0;
    if (handshake) begin
      monitor_next.monitor_ins = 1'b1;
      monitor_next.idx         = bus.req_idx;
      monitor_next.itype       = bus.req_itype;
      monitor_next.two_lane    = bus.req_two_lane;
      monitor_next.lane0       = pick_lane0;
      if (bus.req_two_lane) begin
        monitor_next.lane1 = pick_lane1;
        monitor_next.p_idx = bus.req_p_idx;
      end
    end
  end

  always_comb begin
    stall_cnt_next = '0;
    if (bus.req_valid && !req_ready) begin
      stall_cnt_next = (stall_cnt_reg == '1) ? stall_cnt_reg : stall_cnt_reg + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= RM_ALLOC_RUN;
      free_map_reg  <= '1;
      monitor_reg   <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      free_map_reg  <= free_map_next;
      monitor_reg   <= monitor_next;
      stall_cnt_reg <= stall_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.monitor   = monitor_reg;
  assign free_cnt_o    = free_cnt;
  assign stall_cnt_o   = stall_cnt_reg;
  assign err_o         = err_reg;

endmodule
